// File: rtl/hazard_control_unit_if.sv
// Decode-stage hazard bus between the pipeline and hazard_control_unit.
// The pipeline drives the in* signals; the hazard unit returns stall/nop/flush/halted.
interface hazard_control_unit_if;
    logic [2:0]  inRead1Register;
    logic [2:0]  inRead2Register;
    logic        inRead1Used;
    logic        inRead2Used;
    logic [2:0]  inWriteRegister;
    logic        inRegisterWrite;
    logic        inMemoryRead;
    logic        inHalt;
    logic        inValid;
    logic        inFlush;

    logic        stall;
    logic        nop;
    logic        flush;
    logic        halted;
    logic [15:0] stallCycles;

    // Observation of internal state: FSM state and the two scoreboard slots {valid, reg, load}.
    logic [1:0]  dbg_state_o;
    logic [4:0]  dbg_ex_o;
    logic [4:0]  dbg_mem_o;

    modport master (
        output inRead1Register, inRead2Register, inRead1Used, inRead2Used,
        output inWriteRegister, inRegisterWrite, inMemoryRead, inHalt, inValid, inFlush,
        input  stall, nop, flush, halted, stallCycles,
        input  dbg_state_o, dbg_ex_o, dbg_mem_o
    );

    modport slave (
        input  inRead1Register, inRead2Register, inRead1Used, inRead2Used,
        input  inWriteRegister, inRegisterWrite, inMemoryRead, inHalt, inValid, inFlush,
        output stall, nop, flush, halted, stallCycles,
        output dbg_state_o, dbg_ex_o, dbg_mem_o
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard/stall/flush control with an EX/MEM shadow scoreboard and HALT drain FSM.
// Define HAZARD_FORWARDING_EN for the load-use-only hazard rule; undefined stalls on any RAW in EX or MEM.
module hazard_control_unit (
    input  logic                  clk,
    input  logic                  rst,
    hazard_control_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e      state_q;
    logic [1:0]  drain_cnt_q;
    logic        halted_q;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    logic        ex_valid_q;
    logic [2:0]  ex_reg_q;
    logic        ex_load_q;
    logic        mem_valid_q;
    logic [2:0]  mem_reg_q;
    logic        mem_load_q;

    logic        ex_match;
    logic        data_hazard;
    logic        stall_c;
    logic        nop_c;
    logic        flush_c;
    logic        issue;

    always_comb begin
        ex_match = (bus.inRead1Used & ex_valid_q & (ex_reg_q == bus.inRead1Register)) |
                   (bus.inRead2Used & ex_valid_q & (ex_reg_q == bus.inRead2Register));
    end

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    assign data_hazard = bus.inValid & ex_match & ex_load_q;
`else
    logic mem_match;

    always_comb begin
        mem_match = (bus.inRead1Used & mem_valid_q & (mem_reg_q == bus.inRead1Register)) |
                    (bus.inRead2Used & mem_valid_q & (mem_reg_q == bus.inRead2Register));
    end

    assign data_hazard = bus.inValid & (ex_match | mem_match);
`endif

    // Handshake: decode presents an instruction with inValid; it issues in the cycle where
    // inValid=1 and both stall and nop are low. A flush outranks a data hazard.
    always_comb begin
        stall_c = 1'b0;
        nop_c   = 1'b0;
        flush_c = 1'b0;
        if (!rst) begin
            if (state_q != RUN) begin
                stall_c = 1'b1;
                nop_c   = 1'b1;
            end else if (bus.inFlush) begin
                flush_c = 1'b1;
                nop_c   = 1'b1;
            end else if (data_hazard) begin
                stall_c = 1'b1;
                nop_c   = 1'b1;
            end
        end
    end

    assign issue = bus.inValid & ~stall_c & ~nop_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_reg_q    <= 3'd0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_reg_q   <= 3'd0;
            mem_load_q  <= 1'b0;
        end else begin
            ex_valid_q  <= issue & bus.inRegisterWrite;
            ex_reg_q    <= issue ? bus.inWriteRegister : 3'd0;
            ex_load_q   <= issue & bus.inMemoryRead;
            mem_valid_q <= ex_valid_q;
            mem_reg_q   <= ex_reg_q;
            mem_load_q  <= ex_load_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            drain_cnt_q <= 2'd0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (issue & bus.inHalt) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= 2'd0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == 2'd3) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q     <= RUN;
                    drain_cnt_q <= 2'd0;
                    halted_q    <= 1'b0;
                end
            endcase
        end
    end

    // Drain and halt stalls are intentional, so only RUN-state stalls are counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == RUN) && stall_c && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall       = stall_c;
    assign bus.nop         = nop_c;
    assign bus.flush       = flush_c;
    assign bus.halted      = halted_q & ~rst;
    assign bus.stallCycles = stall_cnt_q;
    assign bus.dbg_state_o = state_q;
    assign bus.dbg_ex_o    = {ex_valid_q, ex_reg_q, ex_load_q};
    assign bus.dbg_mem_o   = {mem_valid_q, mem_reg_q, mem_load_q};
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios plus randomized traffic against a
// register-age reference model (last issue cycle per destination register).
module tb_hazard_control_unit;
  logic clk;
  logic rst;
  hazard_control_unit_if hif();

  hazard_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int vectors;
  int miscompares;

  // Reference model: cycle counter, cycle at which each register was last written by an
  // issued instruction, whether that writer was a load, and a halt mode/drain count.
  int cyc;
  int lw_cyc[8];
  bit lw_load[8];
  int m_mode;
  int m_drain;
  int m_stalls;
  logic e_stall, e_nop, e_flush, e_halted;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit src_hit(input logic [2:0] r);
    int age;
    age = cyc - lw_cyc[r];
    if (FWD) return (age == 1) && lw_load[r];
    return (age == 1) || (age == 2);
  endfunction

  task automatic model_eval();
    bit hz;
    hz = 1'b0;
    if (hif.inValid) begin
      if (hif.inRead1Used && src_hit(hif.inRead1Register)) hz = 1'b1;
      if (hif.inRead2Used && src_hit(hif.inRead2Register)) hz = 1'b1;
    end
    e_stall = 1'b0; e_nop = 1'b0; e_flush = 1'b0; e_halted = 1'b0;
    if (!rst) begin
      if (m_mode == 2) begin
        e_stall = 1'b1; e_nop = 1'b1; e_halted = 1'b1;
      end else if (m_mode == 1) begin
        e_stall = 1'b1; e_nop = 1'b1;
      end else if (hif.inFlush) begin
        e_flush = 1'b1; e_nop = 1'b1;
      end else if (hz) begin
        e_stall = 1'b1; e_nop = 1'b1;
      end
    end
  endtask

  task automatic model_step();
    bit issue;
    if (rst) begin
      m_mode = 0; m_drain = 0; m_stalls = 0;
      for (int i = 0; i < 8; i++) begin lw_cyc[i] = -100; lw_load[i] = 1'b0; end
    end else begin
      issue = hif.inValid && !e_stall && !e_nop;
      if (m_mode == 0 && e_stall && m_stalls < 65535) m_stalls++;
      if (issue && hif.inRegisterWrite) begin
        lw_cyc[hif.inWriteRegister]  = cyc;
        lw_load[hif.inWriteRegister] = hif.inMemoryRead;
      end
      if (m_mode == 0) begin
        if (issue && hif.inHalt) begin m_mode = 1; m_drain = 0; end
      end else if (m_mode == 1) begin
        if (m_drain == 3) m_mode = 2; else m_drain++;
      end
    end
    cyc++;
  endtask

  // Called right after a falling edge: apply inputs, then evaluate the model.
  task automatic drive(input bit v, input bit u1, input bit [2:0] r1, input bit u2,
                       input bit [2:0] r2, input bit we, input bit [2:0] wd, input bit ld,
                       input bit halt, input bit fl);
    hif.inValid = v; hif.inRead1Used = u1; hif.inRead1Register = r1;
    hif.inRead2Used = u2; hif.inRead2Register = r2; hif.inRegisterWrite = we;
    hif.inWriteRegister = wd; hif.inMemoryRead = ld; hif.inHalt = halt; hif.inFlush = fl;
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b0;
  endtask

  // Hold a reader of register r (on src1 or src2) until it issues; report stall cycles seen.
  task automatic count_stalls(input bit [2:0] r, input bit use_src2, output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (use_src2) drive(1, 0, 0, 1, r, 1, 3'd7, 0, 0, 0);
      else          drive(1, 1, r, 0, 0, 1, 3'd7, 0, 0, 0);
      if (hif.stall === 1'b1) n++; else ok = 1'b1;
      advance();
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 3, 1, 4, 1, 5, 1, 0, 1);
    vectors++;
    if ({hif.stall, hif.nop, hif.flush, hif.halted} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0000", {hif.stall, hif.nop, hif.flush, hif.halted});
    end
    advance();
    drive(1, 1, 3, 1, 4, 1, 5, 1, 1, 1);
    vectors++;
    if (hif.stallCycles !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stallcycles: got %0d expected 0", hif.stallCycles);
    end
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (hif.stall !== 1'b0 || hif.halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_run_idle: stall=%b halted=%b expected 0 0", hif.stall, hif.halted);
    end
    vectors++;
    if (hif.dbg_ex_o[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ex_slot: valid=%b expected 0", hif.dbg_ex_o[4]);
    end
    advance();
  endtask

  task automatic test_load_use();
    int n; bit ok;
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 3'd2, 1, 0, 0);
    advance();
    count_stalls(3'd2, 1'b0, n, ok);
    vectors++;
    if (!ok || n != (FWD ? 1 : 2)) begin
      miscompares++;
      $display("FAIL load_use_stalls: got %0d (issued=%0d) expected %0d", n, ok, FWD ? 1 : 2);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (hif.stallCycles !== 16'(FWD ? 1 : 2)) begin
      miscompares++;
      $display("FAIL load_use_count: got %0d expected %0d", hif.stallCycles, FWD ? 1 : 2);
    end
    advance();
  endtask

  task automatic test_raw_distance();
    int n; bit ok;
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 3'd3, 0, 0, 0);
    advance();
    count_stalls(3'd3, 1'b1, n, ok);
    vectors++;
    if (!ok || n != (FWD ? 0 : 2)) begin
      miscompares++;
      $display("FAIL raw_adjacent: got %0d (issued=%0d) expected %0d", n, ok, FWD ? 0 : 2);
    end
    drive(1, 0, 0, 0, 0, 1, 3'd3, 0, 0, 0);
    advance();
    drive(1, 1, 3'd1, 1, 3'd2, 1, 3'd6, 0, 0, 0);
    advance();
    count_stalls(3'd3, 1'b0, n, ok);
    vectors++;
    if (!ok || n != (FWD ? 0 : 1)) begin
      miscompares++;
      $display("FAIL raw_gap_one: got %0d (issued=%0d) expected %0d", n, ok, FWD ? 0 : 1);
    end
  endtask

  task automatic test_flush_hazard();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 3'd5, 1, 0, 0);
    advance();
    drive(1, 1, 3'd5, 0, 0, 1, 3'd1, 0, 0, 1);
    vectors++;
    if ({hif.flush, hif.nop, hif.stall} !== 3'b110) begin
      miscompares++;
      $display("FAIL flush_priority: flush/nop/stall got %b expected 110", {hif.flush, hif.nop, hif.stall});
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (hif.dbg_ex_o[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ex_cleared: valid=%b expected 0", hif.dbg_ex_o[4]);
    end
    vectors++;
    if (hif.stallCycles !== 16'd0) begin
      miscompares++;
      $display("FAIL flush_not_counted: got %0d expected 0", hif.stallCycles);
    end
    advance();
  endtask

  task automatic test_invalid_no_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 3'd4, 1, 0, 0);
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 3'd4, 1, 3'd4, 1, 3'd4, 0, 0, 0);
      vectors++;
      if (hif.stall !== 1'b0 || hif.nop !== 1'b0) begin
        miscompares++;
        $display("FAIL invalid_no_stall[%0d]: stall=%b nop=%b expected 0 0", k, hif.stall, hif.nop);
      end
      advance();
    end
  endtask

  task automatic test_halt_drain();
    int n; bit ok;
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (hif.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_with_flush_ignored: stall=%b expected 0", hif.stall);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 3'd2, 0, 0, 1, 3'd2, 0, 0, 1);
      vectors++;
      if ({hif.stall, hif.nop, hif.flush, hif.halted} !== 4'b1100) begin
        miscompares++;
        $display("FAIL drain[%0d]: stall/nop/flush/halted got %b expected 1100", k,
                 {hif.stall, hif.nop, hif.flush, hif.halted});
      end
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vectors++;
      if ({hif.stall, hif.nop, hif.flush, hif.halted} !== 4'b1101) begin
        miscompares++;
        $display("FAIL halted[%0d]: stall/nop/flush/halted got %b expected 1101", k,
                 {hif.stall, hif.nop, hif.flush, hif.halted});
      end
      advance();
    end
    vectors++;
    if (hif.stallCycles !== 16'd0) begin
      miscompares++;
      $display("FAIL drain_not_counted: got %0d expected 0", hif.stallCycles);
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (hif.halted !== 1'b0 || hif.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_reset: halted=%b stall=%b expected 0 0", hif.halted, hif.stall);
    end
    advance();
    // Reset in the middle of a drain, then a fresh HALT must drain the full four cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (hif.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_drain_reset: stall=%b expected 0", hif.stall);
    end
    advance();
    n = 0; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (hif.halted === 1'b1) begin ok = 1'b1; break; end
      if (hif.stall === 1'b1) n++;
      advance();
    end
    vectors++;
    if (!ok || n != 4) begin
      miscompares++;
      $display("FAIL drain_length: got %0d cycles (halted=%0d) expected 4", n, ok);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 4) != 0, 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
            1'($urandom), 3'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0,
            $urandom_range(0, 9) == 0);
      vectors++;
      if ({hif.stall, hif.nop, hif.flush, hif.halted} !== {e_stall, e_nop, e_flush, e_halted}) begin
        miscompares++;
        $display("FAIL random_ctrl[%0d]: stall/nop/flush/halted got %b expected %b", i,
                 {hif.stall, hif.nop, hif.flush, hif.halted}, {e_stall, e_nop, e_flush, e_halted});
      end
      if (!rst) begin
        vectors++;
        if (hif.stallCycles !== 16'(m_stalls)) begin
          miscompares++;
          $display("FAIL random_count[%0d]: got %0d expected %0d", i, hif.stallCycles, m_stalls);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  // Hold a load in EX and a reader in decode so every cycle is a hazard cycle.
  task automatic test_saturation();
    do_reset();
    force dut.ex_valid_q = 1'b1;
    force dut.ex_reg_q   = 3'd1;
    force dut.ex_load_q  = 1'b1;
    hif.inValid = 1'b1; hif.inRead1Used = 1'b1; hif.inRead1Register = 3'd1;
    hif.inRead2Used = 1'b0; hif.inRead2Register = 3'd0; hif.inRegisterWrite = 1'b1;
    hif.inWriteRegister = 3'd1; hif.inMemoryRead = 1'b0; hif.inHalt = 1'b0; hif.inFlush = 1'b0;
    #1;
    vectors++;
    if (hif.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_hazard: stall=%b expected 1", hif.stall);
    end
    for (int k = 0; k < 65534; k++) begin
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (hif.stallCycles !== 16'd65534) begin
      miscompares++;
      $display("FAIL sat_before: got %0d expected 65534", hif.stallCycles);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (hif.stallCycles !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_hold: got %0h expected ffff", hif.stallCycles);
    end
    release dut.ex_valid_q;
    release dut.ex_reg_q;
    release dut.ex_load_q;
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (hif.stallCycles !== 16'd0) begin
      miscompares++;
      $display("FAIL sat_reset: got %0d expected 0", hif.stallCycles);
    end
    advance();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    cyc = 0; m_mode = 0; m_drain = 0; m_stalls = 0;
    for (int i = 0; i < 8; i++) begin lw_cyc[i] = -100; lw_load[i] = 1'b0; end
    rst = 1'b1;
    hif.inValid = 1'b0; hif.inRead1Used = 1'b0; hif.inRead1Register = 3'd0;
    hif.inRead2Used = 1'b0; hif.inRead2Register = 3'd0; hif.inRegisterWrite = 1'b0;
    hif.inWriteRegister = 3'd0; hif.inMemoryRead = 1'b0; hif.inHalt = 1'b0; hif.inFlush = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_raw_distance();
    test_flush_hazard();
    test_invalid_no_stall();
    test_halt_drain();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
